// File: rtl/seq_shifter_pkg.sv
// Shared types and helpers for the iterative shifter.
// SEQ_SHIFTER_ROTATE_EN adds rotate support throughout.
package seq_shifter_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit entering the vacated end for one single-position step.
  function automatic logic fill_bit(
    input logic lr,
    input logic al,
    input logic rot,
    input logic msb,
    input logic lsb
  );
    logic f;
    if (rot) begin
      f = lr ? msb : lsb;
    end else begin
      f = lr ? 1'b0 : (al & msb);
    end
    return f;
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One-position shift of a data word; combinational.
// SEQ_SHIFTER_ROTATE_EN adds the rot input.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             lr,
  input  logic             al,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic rot_i;
  logic fill;

`ifdef SEQ_SHIFTER_ROTATE_EN
  assign rot_i = rot;
`else
  assign rot_i = 1'b0;
`endif

  always_comb begin
    fill = fill_bit(lr, al, rot_i, d[WIDTH-1], d[0]);
    if (lr) begin
      q = {d[WIDTH-2:0], fill};
    end else begin
      q = {fill, d[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shifter: one bit position per clock, valid/ready in and out.
// SEQ_SHIFTER_ROTATE_EN adds the rot port (rotate instead of shift).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             al,
  input  logic             lr,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             lr_q, lr_d;
  logic             al_q, al_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic             rot_q, rot_d;
`endif

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .lr (lr_q),
    .al (al_q),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rot(rot_q),
`endif
    .d  (data_q),
    .q  (step)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    al_d    = al_q;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_d   = rot_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d = din;
          cnt_d  = shamt;
          lr_d   = lr;
          al_d   = al;
`ifdef SEQ_SHIFTER_ROTATE_EN
          rot_d  = rot;
`endif
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      lr_q        <= 1'b0;
      al_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      lr_q        <= lr_d;
      al_q        <= al_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q       <= rot_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and random bench for seq_shifter.
// Covers rotate cases when SEQ_SHIFTER_ROTATE_EN is defined.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       al = 1'b0;
  logic       lr = 1'b0;
  logic       rot = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] shamt = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shifter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .al       (al),
    .lr       (lr),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rot      (rot),
`endif
    .din      (din),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout)
  );

  function automatic logic [7:0] ref_shift(
    input logic [7:0] d,
    input logic       l,
    input logic       a,
    input logic       r,
    input logic [2:0] s
  );
    logic [15:0] dd;
    logic [7:0]  res;
    dd = {d, d};
    if (r && l) begin
      dd  = dd << s;
      res = dd[15:8];
    end else if (r) begin
      dd  = dd >> s;
      res = dd[7:0];
    end else if (l) begin
      res = d << s;
    end else if (a) begin
      res = 8'($signed(d) >>> s);
    end else begin
      res = d >> s;
    end
    return res;
  endfunction

  // Issues one op from IDLE, scrambles inputs after accept,
  // returns result and cycles from accept-cycle to out_valid.
  task automatic do_op(
    input  logic [7:0] d,
    input  logic       l,
    input  logic       a,
    input  logic       r,
    input  logic [2:0] s,
    output logic [7:0] res,
    output int         lat
  );
    in_valid = 1'b1;
    din = d;
    lr = l;
    al = a;
    rot = r;
    shamt = s;
    @(posedge clk);
    #1;
    lat = 1;
    in_valid = 1'b0;
    din = ~d;
    lr = ~l;
    al = ~a;
    rot = ~r;
    shamt = ~s;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = dout;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout got=%h exp=00", dout);
    end
  endtask

  task automatic test_shift_right();
    logic [7:0] res;
    int lat;
    do_op(8'h96, 1'b0, 1'b0, 1'b0, 3'd3, res, lat);
    checks++;
    if (res !== 8'h12) begin
      errors++;
      $display("FAIL srl_96_3 got=%h exp=12", res);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL srl_latency got=%0d exp=4", lat);
    end
    do_op(8'h96, 1'b0, 1'b1, 1'b0, 3'd3, res, lat);
    checks++;
    if (res !== 8'hF2) begin
      errors++;
      $display("FAIL sra_96_3 got=%h exp=f2", res);
    end
    do_op(8'h16, 1'b0, 1'b1, 1'b0, 3'd3, res, lat);
    checks++;
    if (res !== 8'h02) begin
      errors++;
      $display("FAIL sra_16_3 got=%h exp=02", res);
    end
  endtask

  task automatic test_shift_left();
    logic [7:0] res;
    int lat;
    do_op(8'h96, 1'b1, 1'b1, 1'b0, 3'd3, res, lat);
    checks++;
    if (res !== 8'hB0) begin
      errors++;
      $display("FAIL sll_96_3 got=%h exp=b0", res);
    end
    do_op(8'h96, 1'b1, 1'b0, 1'b0, 3'd0, res, lat);
    checks++;
    if (res !== 8'h96) begin
      errors++;
      $display("FAIL sll_96_0 got=%h exp=96", res);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL shamt0_latency got=%0d exp=1", lat);
    end
    do_op(8'h01, 1'b1, 1'b0, 1'b0, 3'd7, res, lat);
    checks++;
    if (res !== 8'h80) begin
      errors++;
      $display("FAIL sll_01_7 got=%h exp=80", res);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL shamt7_latency got=%0d exp=8", lat);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    in_valid = 1'b1;
    din = 8'h96;
    lr = 1'b1;
    al = 1'b0;
    rot = 1'b0;
    shamt = 3'd3;
    @(posedge clk);
    #1;
    din = 8'h3C;
    lr = 1'b0;
    shamt = 3'd2;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_busy_ready got=%b exp=0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_done got=%b exp=1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 8'hB0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got dout=%h rdy=%b vld=%b exp b0/0/1",
                 i, dout, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b exp 1/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got=%b exp=0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (dout !== 8'h0F || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_result got=%h vld=%b exp=0f/1",
               dout, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat;
    in_valid = 1'b1;
    din = 8'hAA;
    lr = 1'b1;
    al = 1'b0;
    rot = 1'b0;
    shamt = 3'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dout !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got vld=%b dout=%h rdy=%b exp 0/00/1",
               out_valid, dout, in_ready);
    end
    do_op(8'h80, 1'b0, 1'b1, 1'b0, 3'd7, res, lat);
    checks++;
    if (res !== 8'hFF) begin
      errors++;
      $display("FAIL post_reset_sra got=%h exp=ff", res);
    end
  endtask

`ifdef SEQ_SHIFTER_ROTATE_EN
  task automatic test_rotate();
    logic [7:0] res;
    int lat;
    do_op(8'h96, 1'b1, 1'b0, 1'b1, 3'd3, res, lat);
    checks++;
    if (res !== 8'hB4) begin
      errors++;
      $display("FAIL rol_96_3 got=%h exp=b4", res);
    end
    do_op(8'h96, 1'b0, 1'b1, 1'b1, 3'd1, res, lat);
    checks++;
    if (res !== 8'h4B) begin
      errors++;
      $display("FAIL ror_96_1 got=%h exp=4b", res);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] res;
    logic [7:0] exp;
    logic       l;
    logic       a;
    logic       r;
    logic [2:0] s;
    int lat;
    for (int i = 0; i < 10000; i++) begin
      d = 8'($urandom);
      l = 1'($urandom);
      a = 1'($urandom);
      s = 3'($urandom);
`ifdef SEQ_SHIFTER_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      exp = ref_shift(d, l, a, r, s);
      do_op(d, l, a, r, s, res, lat);
      checks++;
      if (res !== exp || lat !== int'(s) + 1) begin
        errors++;
        $display("FAIL rand%0d d=%h lr=%b al=%b rot=%b sh=%0d got=%h lat=%0d exp=%h lat=%0d",
                 i, d, l, a, r, s, res, lat, exp, int'(s) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_shift_left();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_SHIFTER_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
